// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic [BW-1:0]   r_baud;
  logic            r_tx;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  logic            w_push;
  logic            w_pop;
  logic            w_baud_done;
  logic            w_not_empty;
  logic [7:0]      w_shift_nxt;
  logic            w_tx_nxt;

  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_not_empty = (r_level != '0);
  assign tx_ready    = (r_level != LVL_FULL);
  assign w_push      = tx_valid && tx_ready;
  assign tx          = r_tx;
  assign level       = r_level;
  assign busy        = (r_state != S_IDLE) || w_not_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_baud_done) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_done && (r_bitcnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_baud_done) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        // back-to-back frames: pop on the stop-bit's final edge
        if (w_baud_done) begin
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_shift_nxt = r_shift;
    if (w_pop) begin
      w_shift_nxt = r_mem[r_rptr];
    end else if ((r_state == S_DATA) && w_baud_done) begin
      w_shift_nxt = r_shift >> 1;
    end

    // line level is registered from the state being entered
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_baud   <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if ((r_state == S_IDLE) || w_baud_done) r_baud <= '0;
      else                                   r_baud <= r_baud + BAUD_ONE;
      if (r_state != S_DATA)  r_bitcnt <= '0;
      else if (w_baud_done)   r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rptr];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timeline model checked every cycle, a line receiver,
// and directed literal checks. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected line level t cycles after the start of a frame carrying b
  function automatic logic exp_line(input logic [7:0] b, input int t);
    int k;
    k = t / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_act;
  bit         m_push;
  int         m_t;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      m_push = tx_valid && (mq.size() < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == FL) m_act = 1'b0;
      end
      if (!m_act && mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_t   = 0;
      end
      if (m_push) mq.push_back(tx_data);
    end
    #1;
    if (rst_n) begin
      chk("model_tx", tx, m_act ? exp_line(m_cur, m_t) : 1'b1);
      chk("model_level", level, mq.size());
      chk("model_tx_ready", tx_ready, mq.size() != DEPTH);
      chk("model_busy", busy, m_act || (mq.size() != 0));
    end
  end

  logic [7:0] rxq[$];
  logic [7:0] rx_b;
  bit         rx_ok;
  int         rx_err = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n && tx === 1'b0) begin
        repeat (DIV / 2) @(posedge clk);
        #1;
        rx_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          rx_b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(posedge clk);
        #1;
        rx_ok = rx_ok && (tx === ^rx_b);
`endif
        repeat (DIV) @(posedge clk);
        #1;
        rx_ok = rx_ok && (tx === 1'b1);
        if (!rx_ok) rx_err++;
        rxq.push_back(rx_b);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [7:0] b, output int e);
    int g;
    g = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("push_stall_bound", g < 1000, 1);
    @(posedge clk); #1;
    e = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_bound", n < limit, 1);
  endtask

  int e, ea, ef, e1, ed;
  logic [7:0] burst [6];
  logic [7:0] hi [3];
  string s;

  initial begin
    burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    hi    = '{8'h48, 8'h69, 8'h0D};

    repeat (5) @(posedge clk);
    #1;
    chk("reset_held_tx", tx, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_tx", tx, 1);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);

    // single byte 0x55
    push(8'h55, e);
    idle_in();
    chk("single_busy_at_push", busy, 1);
    chk("single_level_at_push", level, 1);
    goto(e + 1);  chk("single_start_first", tx, 0);
    goto(e + 10); chk("single_start_last", tx, 0);
    goto(e + 11); chk("single_bit0", tx, 1);
    goto(e + 21); chk("single_bit1", tx, 0);
    goto(e + 81); chk("single_bit7", tx, 0);
`ifdef UART_TX_PARITY_EN
    goto(e + 91); chk("single_parity", tx, 0);
`else
    goto(e + 91); chk("single_stop", tx, 1);
`endif
    goto(e + FL);     chk("single_busy_last", busy, 1);
    goto(e + FL + 1); chk("single_busy_fall", busy, 0);

    // burst with backpressure
    rxq.delete();
    push(burst[0], ea); chk("burst_level_a", level, 1);
    push(burst[1], e);  chk("burst_level_b", level, 1);
    push(burst[2], e);  chk("burst_level_c", level, 2);
    push(burst[3], e);  chk("burst_level_d", level, 3);
    push(burst[4], e);  chk("burst_level_e", level, 4);
    chk("burst_full_ready", tx_ready, 0);
    push(burst[5], ef);
    idle_in();
    chk("burst_f_accept_edge", ef, ea + FL + 2);
    goto(ea + 6 * FL);     chk("burst_busy_last", busy, 1);
    goto(ea + 6 * FL + 1); chk("burst_busy_fall", busy, 0);
    chk("burst_rx_count", rxq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rxq.size()) chk($sformatf("burst_rx_%0d", i), rxq[i], burst[i]);
    end

    // loopback text
    rxq.delete();
    for (int i = 0; i < 3; i++) push(hi[i], e);
    idle_in();
    wait_idle(5000);
    chk("loop_rx_count", rxq.size(), 3);
    s = "";
    for (int i = 0; i < 3; i++) begin
      if (i < rxq.size()) begin
        chk($sformatf("loop_rx_%0d", i), rxq[i], hi[i]);
        if (i < 2) s = $sformatf("%s%c", s, rxq[i]);
      end
    end
    $display("loopback text: %s", s);

`ifdef UART_TX_PARITY_EN
    push(8'h07, e);
    idle_in();
    goto(e + 90);  chk("par_bit7", tx, 0);
    goto(e + 91);  chk("par_first", tx, 1);
    goto(e + 100); chk("par_last", tx, 1);
    goto(e + 101); chk("par_stop", tx, 1);
    goto(e + 110); chk("par_busy_last", busy, 1);
    goto(e + 111); chk("par_busy_fall", busy, 0);
`endif

    chk("rx_framing_errors", rx_err, 0);

    // reset during DATA of 0xA3 with two bytes queued
    push(8'hA3, e1);
    push(8'h5A, e);
    push(8'hC3, e);
    idle_in();
    chk("midrst_level_queued", level, 2);
    goto(e1 + 36);
    chk("midrst_bit2", tx, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", tx, 1);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ed = cyc + 300;
    goto(ed);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable 8N1 UART transmitter with a small byte FIFO. It accepts bytes from on-chip logic over a valid/ready handshake and serializes them LSB-first on `tx`. `tx` is the line that the UART bench model samples as its `RX` input. Frame format, idle level and bit time match that model so a bench can wire the two together directly.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD`, 115200: line rate; bit time `DIV = CLK_FREQ/BAUD` cycles, integer-truncated; requires DIV ≥ 2.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` valid this cycle.
- `tx_ready` out 1: FIFO can accept; equals `level != DEPTH`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: equals `(state != IDLE) || (level != 0)`.
- `level` out `$clog2(DEPTH)+1`: FIFO occupancy.

## Operation
- Push: a byte is written on each rising edge where `tx_valid && tx_ready`. `tx_data` is ignored otherwise. A push while full cannot occur because `tx_ready` is 0.
- Pop: in IDLE with `level != 0`, the head byte is loaded into the shift register at the next edge. That edge also enters START and resets the baud counter.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → (IDLE, or START if FIFO non-empty).
- `tx` value by state:
  - IDLE: 1.
  - START: 0.
  - DATA: `shift[0]`; the register shifts right once per bit; bit counter runs 0..7.
  - STOP: 1.
- Baud counter counts 0..DIV-1. A state or bit advance happens on the edge where the count equals DIV-1, and the counter then returns to 0.
- Back-to-back: if the FIFO is non-empty at the end of STOP, the pop happens on the same edge and START follows with no idle cycle.
- Simultaneous push and pop: both take effect on the same edge and `level` is unchanged.
- Pointers wrap modulo DEPTH. `level` saturates structurally at DEPTH and never goes negative.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `level`=0, state IDLE, FIFO pointers 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and FIFO contents are discarded. After release the block is idle with no partial frame.
- Latency: push accepted at edge E with FIFO empty and FSM idle → pop at edge E+1 → `tx` falls after E+1.
- Each bit is exactly DIV cycles. A frame is 10·DIV cycles, or 11·DIV with parity.
- `tx` is driven from a register, so it has no combinational path from inputs.
- `tx_ready` is combinational from `level` only.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles, giving a frame of 11·DIV.
- `UART_TX_PARITY_EN` undefined: strict 8N1, a frame of 10·DIV, and no parity logic is present. This is the default and the mode that is compatible with the bench model.

## Test plan
Test-plan parameters: CLK_FREQ=1000000, BAUD=100000, so DIV=10.

- **Reset:** hold `rst_n`=0 for 5 cycles, then release → `tx`=1, `tx_ready`=1, `busy`=0, `level`=0.
- **Single byte:** push 0x55 at edge E → `tx`=0 for cycles E+1..E+10. Data bits 1,0,1,0,1,0,1,0 each for 10 cycles, then stop=1 for 10 cycles. `busy` falls 100 cycles after E+1.
- **Burst and backpressure:** push A..E on 5 consecutive cycles → `level` goes 1,1,2,3,4 and `tx_ready`=0 after E. A 6th push (F) stalls until A's stop bit ends, then is accepted. Bytes are sent A..F with no idle gap between frames.
- **Model loopback:** connect `tx` to the bench model's RX and send 0x48, 0x69, 0x0D → the model prints bytes "Hi". Check with and without `UART_TX_PARITY_EN` undefined.
- **Reset mid-frame:** assert `rst_n` during DATA of 0xA3 with 2 bytes queued → `tx`=1 immediately and `level`=0. After release, no further frames are sent.
- **Parity (macro defined):** send 0x07 → parity bit = 1 on cycles 91..100 after the start. Frame length is 110 cycles.
